// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU controller: FSM states, instruction
// classes, opcode/op encodings, ALU operations and IR field positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_MOV_IMM = 3'd0,
        CLS_MOV_REG = 3'd1,
        CLS_ADD     = 3'd2,
        CLS_CMP     = 3'd3,
        CLS_AND     = 3'd4,
        CLS_MVN     = 3'd5,
        CLS_UNDEF   = 3'd6
    } instr_class_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam int OPCODE_LSB = 13;
    localparam int OP_LSB     = 11;
    localparam int RN_LSB     = 8;
    localparam int RD_LSB     = 5;
    localparam int SH_LSB     = 3;
    localparam int RM_LSB     = 0;
    localparam int IMM8_LSB   = 0;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Handshake and datapath-control bundle between the system/datapath side
// (master) and the controller (slave).
interface cpu_controller_if;
    logic        s;
    logic        load;
    logic [15:0] instr_in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic        vsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] datapath_in;

    modport master (
        output s, load, instr_in,
        input  w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop, datapath_in
    );

    modport slave (
        input  s, load, instr_in,
        output w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop, datapath_in
    );
endinterface

// File: rtl/instr_decoder.sv
// Combinational split of the instruction register into its fields, the
// sign-extended 8-bit immediate and the instruction class.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0]  ir,
    output instr_class_t cls,
    output logic [1:0]   op,
    output logic [2:0]   rn,
    output logic [2:0]   rd,
    output logic [1:0]   sh,
    output logic [2:0]   rm,
    output logic [15:0]  sximm8
);
    logic [2:0] opcode;

    assign opcode = ir[OPCODE_LSB +: 3];
    assign op     = ir[OP_LSB +: 2];
    assign rn     = ir[RN_LSB +: 3];
    assign rd     = ir[RD_LSB +: 3];
    assign sh     = ir[SH_LSB +: 2];
    assign rm     = ir[RM_LSB +: 3];
    assign sximm8 = sext8(ir[IMM8_LSB +: 8]);

    always_comb begin
        cls = CLS_UNDEF;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
            else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  cls = CLS_ADD;
                OP_CMP:  cls = CLS_CMP;
                OP_AND:  cls = CLS_AND;
                default: cls = CLS_MVN;
            endcase
        end
    end
endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus the Moore sequencing FSM that drives the datapath
// through fetch/execute/writeback for one instruction per start strobe.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    cpu_controller_if.slave bus
);
    state_t       state_q, state_d;
    logic [15:0]  ir_q, ir_d;

    instr_class_t cls;
    logic [1:0]   op;
    logic [2:0]   rn;
    logic [2:0]   rd;
    logic [1:0]   sh;
    logic [2:0]   rm;
    logic [15:0]  sximm8;

    instr_decoder u_dec (
        .ir     (ir_q),
        .cls    (cls),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (sximm8)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // IR only moves while idle, so a load coinciding with s is the one executed.
    always_comb begin
        ir_d = ir_q;
        if (bus.load && (state_q == S_WAIT)) ir_d = bus.instr_in;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (bus.s) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (cls)
                    CLS_MOV_IMM:          state_d = S_WR_IMM;
                    CLS_MOV_REG, CLS_MVN: state_d = S_GET_B;
                    CLS_ADD, CLS_CMP,
                    CLS_AND:              state_d = S_GET_A;
                    default:              state_d = S_WAIT;
                endcase
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            S_EXEC:   state_d = (cls == CLS_CMP) ? S_WAIT : S_WR_REG;
            S_WR_REG: state_d = S_WAIT;
            S_WR_IMM: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_comb begin
        bus.w        = 1'b0;
        bus.readnum  = 3'd0;
        bus.writenum = 3'd0;
        bus.write    = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.vsel     = 1'b0;
        bus.shift    = 2'b00;
        bus.ALUop    = ALU_ADD;
        case (state_q)
            S_WAIT: bus.w = 1'b1;
            S_GET_A: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
            end
            S_GET_B: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
            end
            S_EXEC: begin
                // The op field doubles as the ALU code; MOV reg passes B through an add with A zeroed.
                bus.shift = sh;
                bus.ALUop = (cls == CLS_MOV_REG) ? ALU_ADD : op;
                bus.asel  = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
                if (cls == CLS_CMP) bus.loads = 1'b1;
                else                bus.loadc = 1'b1;
            end
            S_WR_REG: begin
                bus.writenum = rd;
                bus.write    = 1'b1;
            end
            S_WR_IMM: begin
                bus.writenum = rn;
                bus.vsel     = 1'b1;
                bus.write    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.datapath_in = sximm8;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: stimulus pushes the expected busy-cycle
// control vectors, a negedge monitor pops and compares them.
module tb_cpu_controller;

    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       vsel;
        logic [1:0] shift;
        logic [1:0] aluop;
    } ctl_t;

    typedef enum int {K_MOVI, K_MOVR, K_ADD, K_CMP, K_AND, K_MVN, K_UNDEF} kind_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    cpu_controller_if bus_if();

    cpu_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    ctl_t        exp_q[$];
    logic [15:0] model_ir = 16'h0000;
    int          exp_busy = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic ctl_t act_ctl();
        ctl_t c;
        c.readnum  = bus_if.readnum;
        c.writenum = bus_if.writenum;
        c.write    = bus_if.write;
        c.loada    = bus_if.loada;
        c.loadb    = bus_if.loadb;
        c.loadc    = bus_if.loadc;
        c.loads    = bus_if.loads;
        c.asel     = bus_if.asel;
        c.bsel     = bus_if.bsel;
        c.vsel     = bus_if.vsel;
        c.shift    = bus_if.shift;
        c.aluop    = bus_if.ALUop;
        return c;
    endfunction

    function automatic kind_t classify(input logic [15:0] ir);
        case ({ir[15:13], ir[12:11]})
            5'b110_10: return K_MOVI;
            5'b110_00: return K_MOVR;
            5'b101_00: return K_ADD;
            5'b101_01: return K_CMP;
            5'b101_10: return K_AND;
            5'b101_11: return K_MVN;
            default:   return K_UNDEF;
        endcase
    endfunction

    function automatic logic [15:0] sext(input logic [15:0] ir);
        return {{8{ir[7]}}, ir[7:0]};
    endfunction

    // Expected control vector for every busy cycle of one instruction, in order.
    task automatic push_expect(input logic [15:0] ir);
        kind_t k;
        ctl_t  t;
        k = classify(ir);
        exp_q.push_back('0);
        exp_busy = 1;
        if (k == K_MOVI) begin
            t = '0; t.writenum = ir[10:8]; t.vsel = 1'b1; t.write = 1'b1;
            exp_q.push_back(t); exp_busy++;
        end else if (k != K_UNDEF) begin
            if (k == K_ADD || k == K_CMP || k == K_AND) begin
                t = '0; t.readnum = ir[10:8]; t.loada = 1'b1;
                exp_q.push_back(t); exp_busy++;
            end
            t = '0; t.readnum = ir[2:0]; t.loadb = 1'b1;
            exp_q.push_back(t); exp_busy++;
            t = '0;
            t.shift = ir[4:3];
            t.aluop = (k == K_MOVR) ? 2'b00 : ir[12:11];
            t.asel  = (k == K_MOVR || k == K_MVN);
            if (k == K_CMP) t.loads = 1'b1;
            else            t.loadc = 1'b1;
            exp_q.push_back(t); exp_busy++;
            if (k != K_CMP) begin
                t = '0; t.writenum = ir[7:5]; t.write = 1'b1;
                exp_q.push_back(t); exp_busy++;
            end
        end
    endtask

    // Counts busy negedges until idle; optionally hammers load while busy.
    task automatic wait_idle(input bit busy_load, input logic [15:0] busy_word, output int n);
        bit done;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus_if.w) begin
                done = 1'b1;
            end else begin
                n++;
                if (busy_load) begin
                    bus_if.load     = 1'b1;
                    bus_if.instr_in = busy_word;
                end
                if (n >= 20) begin
                    checks++;
                    failures++;
                    $display("FAIL idle_timeout actual=busy_for_%0d required=idle", n);
                    done = 1'b1;
                end
            end
        end
        bus_if.load = 1'b0;
    endtask

    task automatic run_instr(input bit with_load, input logic [15:0] word,
                             input bit busy_load, input logic [15:0] busy_word);
        int n;
        bus_if.s        = 1'b1;
        bus_if.load     = with_load;
        bus_if.instr_in = word;
        @(posedge clk);
        if (with_load) model_ir = word;
        push_expect(model_ir);
        #1;
        bus_if.s    = 1'b0;
        bus_if.load = 1'b0;
        wait_idle(busy_load, busy_word, n);
        check("busy_cycles", n, exp_busy);
    endtask

    task automatic b2b(input int n_instr);
        int guard;
        int n;
        bus_if.s = 1'b1;
        for (int k = 0; k < n_instr; k++) begin
            if (k > 0) begin
                guard = 0;
                do begin
                    @(negedge clk);
                    guard++;
                end while (!bus_if.w && guard < 20);
                if (!bus_if.w) begin
                    checks++;
                    failures++;
                    $display("FAIL b2b_timeout actual=w0 required=w1");
                end
            end
            @(posedge clk);
            push_expect(model_ir);
        end
        #1;
        bus_if.s = 1'b0;
        wait_idle(1'b0, 16'h0000, n);
        check("b2b_busy_cycles", n, exp_busy);
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 6))
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2: r[15:11] = 5'b10100;
            3: r[15:11] = 5'b10101;
            4: r[15:11] = 5'b10110;
            5: r[15:11] = 5'b10111;
            default: r[15:13] = 3'($urandom_range(0, 4));
        endcase
        return r;
    endfunction

    // Monitor: every negedge, busy cycles consume one expected vector.
    initial begin
        ctl_t a;
        ctl_t e;
        forever begin
            @(negedge clk);
            a = act_ctl();
            check("datapath_in", bus_if.datapath_in, sext(model_ir));
            if (!bus_if.w) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_busy actual=w0 ctl=0x%0h required=w1", a);
                end else begin
                    e = exp_q.pop_front();
                    check("busy_ctl", a, e);
                end
            end else begin
                check("idle_ctl", a, 32'h0);
                if (exp_q.size() != 0) begin
                    checks++;
                    failures++;
                    $display("FAIL busy_too_short actual=idle remaining=%0d required=0", exp_q.size());
                    exp_q.delete();
                end
            end
        end
    end

    initial begin
        logic [15:0] word;
        bus_if.s        = 1'b0;
        bus_if.load     = 1'b0;
        bus_if.instr_in = 16'h0000;
        reset           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_w", bus_if.w, 1);
        check("reset_ctl", act_ctl(), 32'h0);
        check("reset_datapath_in", bus_if.datapath_in, 16'h0000);
        reset = 1'b0;

        run_instr(1'b1, 16'hD007, 1'b0, 16'h0);
        run_instr(1'b1, 16'hD1FE, 1'b0, 16'h0);
        check("movimm_neg_dp", bus_if.datapath_in, 16'hFFFE);
        run_instr(1'b1, 16'hA148, 1'b0, 16'h0);
        run_instr(1'b1, 16'hA801, 1'b0, 16'h0);
        run_instr(1'b1, 16'hA148, 1'b1, 16'h0000);
        check("ir_kept_dp", bus_if.datapath_in, 16'h0048);
        run_instr(1'b1, 16'h0000, 1'b0, 16'h0);

        for (int t = 0; t < 60; t++) begin
            word = rand_word();
            run_instr($urandom_range(0, 3) != 0, word, $urandom_range(0, 2) == 0, 16'($urandom));
        end

        for (int t = 0; t < 6; t++) begin
            run_instr(1'b1, rand_word(), 1'b0, 16'h0);
            b2b(3);
        end

        // Reset while the ADD sits in GET_A.
        bus_if.s        = 1'b1;
        bus_if.load     = 1'b1;
        bus_if.instr_in = 16'hA148;
        @(posedge clk);
        model_ir = 16'hA148;
        push_expect(model_ir);
        #1;
        bus_if.s    = 1'b0;
        bus_if.load = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        model_ir = 16'h0000;
        #1;
        check("midreset_w", bus_if.w, 1);
        check("midreset_ctl", act_ctl(), 32'h0);
        check("midreset_dp", bus_if.datapath_in, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(1'b0, 16'h0, 1'b0, 16'h0);
        run_instr(1'b1, 16'hB8E3, 1'b0, 16'h0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
